// File: rtl/eth_port_pkg.sv
// Shared types and default sizing for the
// Ethernet receive-port merge block.
package eth_port_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PASS,
    DROP
  } state_t;

  localparam int DEF_NUM_PORTS = 4;
  localparam int DEF_DATA_W    = 64;
  localparam int DEF_MAX_BEATS = 256;
  localparam int DEF_CNT_W     = 32;

endpackage

// File: rtl/eth_rr_arbiter.sv
// Round-robin request picker; search starts
// at the port just after the previous grant.
module eth_rr_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int PORT_W    = 2
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [PORT_W-1:0]    last,
  output logic [NUM_PORTS-1:0] grant,
  output logic [PORT_W-1:0]    grant_idx,
  output logic                 valid
);

  // first requester after last, wrapping
  always_comb begin
    int j;
    logic [PORT_W-1:0] idx;
    grant     = '0;
    grant_idx = '0;
    valid     = 1'b0;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      j = int'(last) + i;
      if (j >= NUM_PORTS) j = j - NUM_PORTS;
      idx = PORT_W'(j);
      if (!valid && req[idx]) begin
        valid      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/eth_port_rx_mux.sv
// Merges per-port MAC receive streams into one
// frame-atomic stream with truncation and stats.
module eth_port_rx_mux
  import eth_port_pkg::*;
#(
  parameter int NUM_PORTS = DEF_NUM_PORTS,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MAX_BEATS = DEF_MAX_BEATS,
  parameter int CNT_W     = DEF_CNT_W,
  localparam int KEEP_W   = DATA_W / 8,
  localparam int PORT_W   =
    (NUM_PORTS > 2) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                  user_clk,
  input  logic                  axis_aresetn,
  input  logic [NUM_PORTS-1:0][DATA_W-1:0] s_axis_tdata,
  input  logic [NUM_PORTS-1:0][KEEP_W-1:0] s_axis_tkeep,
  input  logic [NUM_PORTS-1:0]  s_axis_tvalid,
  input  logic [NUM_PORTS-1:0]  s_axis_tlast,
  output logic [NUM_PORTS-1:0]  s_axis_tready,
  input  logic [NUM_PORTS-1:0]  port_en,
  output logic [DATA_W-1:0]     m_axis_tdata,
  output logic [KEEP_W-1:0]     m_axis_tkeep,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,
  output logic [PORT_W-1:0]     m_axis_tport,
  output logic                  m_axis_terr,
  output logic [NUM_PORTS-1:0][CNT_W-1:0] frame_cnt,
  output logic [NUM_PORTS-1:0][CNT_W-1:0] drop_cnt
);

  localparam int BEAT_W = $clog2(MAX_BEATS);

  state_t                state;
  logic [PORT_W-1:0]     grant_idx;
  logic [NUM_PORTS-1:0]  grant_oh;
  logic [BEAT_W-1:0]     beat_cnt;
  logic                  from_idle;

  logic [NUM_PORTS-1:0]  arb_grant;
  logic [PORT_W-1:0]     arb_idx;
  logic                  arb_valid;

  logic                  out_rdy;
  logic                  acc;
  logic                  at_max;
  logic [DATA_W-1:0]     sel_data;
  logic [KEEP_W-1:0]     sel_keep;
  logic                  sel_last;

  eth_rr_arbiter #(
    .NUM_PORTS (NUM_PORTS),
    .PORT_W    (PORT_W)
  ) u_arb (
    .req       (s_axis_tvalid),
    .last      (grant_idx),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .valid     (arb_valid)
  );

  assign out_rdy  = !m_axis_tvalid || m_axis_tready;
  assign sel_data = s_axis_tdata[grant_idx];
  assign sel_keep = s_axis_tkeep[grant_idx];
  assign sel_last = s_axis_tlast[grant_idx];
  assign acc      = |(s_axis_tvalid & s_axis_tready);
  assign at_max   =
    (beat_cnt == BEAT_W'(MAX_BEATS - 1));

  // only the granted port sees ready
  always_comb begin
    s_axis_tready = '0;
    unique case (state)
      PASS: s_axis_tready =
        grant_oh & {NUM_PORTS{out_rdy}};
      DROP: s_axis_tready = grant_oh;
      default: s_axis_tready = '0;
    endcase
  end

  // frame FSM, output register and stats
  always_ff @(posedge user_clk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      state         <= IDLE;
      grant_idx     <= PORT_W'(NUM_PORTS - 1);
      grant_oh      <= '0;
      beat_cnt      <= '0;
      from_idle     <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_terr   <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tport  <= '0;
      frame_cnt     <= '0;
      drop_cnt      <= '0;
    end else begin
      if (m_axis_tvalid && m_axis_tready)
        m_axis_tvalid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (arb_valid) begin
            grant_idx <= arb_idx;
            grant_oh  <= arb_grant;
            beat_cnt  <= '0;
            from_idle <= !port_en[arb_idx];
            state     <= port_en[arb_idx] ? PASS : DROP;
          end
        end
        PASS: begin
          if (acc) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= sel_data;
            m_axis_tkeep  <= sel_keep;
            m_axis_tport  <= grant_idx;
            m_axis_tlast  <= sel_last || at_max;
            m_axis_terr   <= !sel_last && at_max;
            beat_cnt      <= beat_cnt + BEAT_W'(1);
            if (sel_last || at_max) begin
              frame_cnt[grant_idx] <=
                frame_cnt[grant_idx] + CNT_W'(1);
              from_idle <= 1'b0;
              state     <= sel_last ? IDLE : DROP;
            end
          end
        end
        DROP: begin
          if (acc && sel_last) begin
            if (from_idle)
              drop_cnt[grant_idx] <=
                drop_cnt[grant_idx] + CNT_W'(1);
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_port_rx_mux.sv
// Self-checking bench: directed table, corner
// sequences and randomized frames vs a frame model.
module tb_eth_port_rx_mux;

  localparam int NP = 4;
  localparam int DW = 32;
  localparam int KW = 4;
  localparam int MB = 4;
  localparam int CW = 32;
  localparam int PW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   rst_n;
  logic [NP-1:0][DW-1:0]  s_tdata;
  logic [NP-1:0][KW-1:0]  s_tkeep;
  logic [NP-1:0]          s_tvalid;
  logic [NP-1:0]          s_tlast;
  logic [NP-1:0]          s_tready;
  logic [NP-1:0]          port_en;
  logic [DW-1:0]          m_tdata;
  logic [KW-1:0]          m_tkeep;
  logic                   m_tvalid;
  logic                   m_tlast;
  logic                   m_tready;
  logic [PW-1:0]          m_tport;
  logic                   m_terr;
  logic [NP-1:0][CW-1:0]  frame_cnt;
  logic [NP-1:0][CW-1:0]  drop_cnt;

  eth_port_rx_mux #(
    .NUM_PORTS (NP),
    .DATA_W    (DW),
    .MAX_BEATS (MB),
    .CNT_W     (CW)
  ) dut (
    .user_clk      (clk),
    .axis_aresetn  (rst_n),
    .s_axis_tdata  (s_tdata),
    .s_axis_tkeep  (s_tkeep),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tlast  (s_tlast),
    .s_axis_tready (s_tready),
    .port_en       (port_en),
    .m_axis_tdata  (m_tdata),
    .m_axis_tkeep  (m_tkeep),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tlast  (m_tlast),
    .m_axis_tready (m_tready),
    .m_axis_tport  (m_tport),
    .m_axis_terr   (m_terr),
    .frame_cnt     (frame_cnt),
    .drop_cnt      (drop_cnt)
  );

  typedef struct packed {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic          l;
    logic          e;
  } beat_t;

  typedef struct {
    logic [NP-1:0] en;
    int len[NP];
    int fc[NP];
    int dc[NP];
    int beats;
    int errs;
    int gap;
  } vec_t;

  beat_t src_q[NP][$];
  beat_t exp_q[NP][$];
  int src_idx[NP];
  int mdl_fc[NP];
  int mdl_dc[NP];
  int rdy_cyc[NP];
  int nfr[NP];
  int exp_order[$];
  int obs_order[$];
  int obs_cyc[$];
  int n_out, n_err, n_stall, cyc;
  int nchk = 0, npass = 0;
  int rdy_mode = 0;
  int pat_i = 0;
  int serial = 0;
  bit gaps = 0;
  bit new_frame = 1;

  task automatic chk(string name, longint act,
                     longint exp);
    nchk++;
    if (act == exp) npass++;
    else
      $display("FAIL %s: got %0h, required %0h",
               name, act, exp);
  endtask

  task automatic check_beat(int p, beat_t b);
    n_out++;
    if (b.e) n_err++;
    if (new_frame) begin
      obs_order.push_back(p);
      obs_cyc.push_back(cyc);
    end
    new_frame = b.l;
    if (exp_q[p].size() == 0) begin
      nchk++;
      $display("FAIL unexpected_beat p%0d: got %h, required none",
               p, b.d);
    end else begin
      chk($sformatf("beat_p%0d", p), longint'(b),
          longint'(exp_q[p][0]));
      void'(exp_q[p].pop_front());
    end
  endtask

  // source driver and output monitor
  initial begin
    logic [NP-1:0] acc;
    beat_t ob;
    int ob_p;
    bit have_ob;
    bit prev_stall;
    logic [DW+KW+PW+2:0] prev_v, cur_v;
    prev_stall = 0;
    prev_v = '0;
    forever begin
      @(negedge clk);
      for (int p = 0; p < NP; p++) begin
        if (src_q[p].size() > 0 &&
            !(gaps && src_idx[p] > 0 &&
              $urandom_range(0, 3) == 0)) begin
          s_tvalid[p] = 1'b1;
          s_tdata[p]  = src_q[p][0].d;
          s_tkeep[p]  = src_q[p][0].k;
          s_tlast[p]  = src_q[p][0].l;
        end else begin
          s_tvalid[p] = 1'b0;
          s_tdata[p]  = '0;
          s_tkeep[p]  = '0;
          s_tlast[p]  = 1'b0;
        end
      end
      case (rdy_mode)
        0: m_tready = 1'b1;
        1: begin
          m_tready = (pat_i % 4 == 0) ||
                     (pat_i % 4 == 3);
          pat_i++;
        end
        default: m_tready = ($urandom_range(0, 3) != 0);
      endcase
      #1;
      have_ob = 0;
      ob = '0;
      ob_p = 0;
      if (rst_n) begin
        cur_v = {m_tdata, m_tkeep, m_tport,
                 m_tlast, m_terr, m_tvalid};
        if (prev_stall) begin
          n_stall++;
          chk("stall_hold", longint'(cur_v),
              longint'(prev_v));
        end
        prev_stall = m_tvalid && !m_tready;
        prev_v = cur_v;
        if (m_tvalid && m_tready) begin
          have_ob = 1;
          ob = '{m_tdata, m_tkeep, m_tlast, m_terr};
          ob_p = int'(m_tport);
        end
        for (int p = 0; p < NP; p++)
          if (s_tready[p]) rdy_cyc[p]++;
      end else begin
        prev_stall = 0;
      end
      acc = s_tvalid & s_tready;
      @(posedge clk);
      cyc++;
      if (rst_n) begin
        for (int p = 0; p < NP; p++) begin
          if (acc[p]) begin
            src_idx[p] = src_q[p][0].l ? 0 : src_idx[p] + 1;
            void'(src_q[p].pop_front());
          end
        end
        if (have_ob) check_beat(ob_p, ob);
      end
    end
  end

  task automatic clear_obs();
    for (int p = 0; p < NP; p++) begin
      exp_q[p].delete();
      mdl_fc[p] = 0;
      mdl_dc[p] = 0;
      rdy_cyc[p] = 0;
      nfr[p] = 0;
    end
    exp_order.delete();
    obs_order.delete();
    obs_cyc.delete();
    n_out = 0;
    n_err = 0;
    n_stall = 0;
    new_frame = 1;
    pat_i = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #3 rst_n = 1'b0;
    for (int p = 0; p < NP; p++) begin
      src_q[p].delete();
      src_idx[p] = 0;
    end
    clear_obs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #3 rst_n = 1'b1;
  endtask

  // model: a frame is forwarded clipped to MB beats
  task automatic load_frame(int p, int len);
    for (int b = 0; b < len; b++) begin
      beat_t x;
      x.d = {4'(p), 12'(serial), 8'(b), 8'($urandom)};
      x.k = 4'($urandom_range(1, 15));
      x.l = (b == len - 1);
      x.e = 1'b0;
      src_q[p].push_back(x);
      if (port_en[p] && b < MB) begin
        beat_t y;
        y = x;
        y.l = (b == len - 1) || (b == MB - 1);
        y.e = (b == MB - 1) && (len > MB);
        exp_q[p].push_back(y);
      end
    end
    if (port_en[p]) mdl_fc[p]++;
    else mdl_dc[p]++;
    serial++;
  endtask

  // model: whole frames granted in rotation from port 0
  task automatic build_order();
    int rem[NP];
    int ptr;
    int total;
    ptr = NP - 1;
    total = 0;
    for (int p = 0; p < NP; p++) begin
      rem[p] = nfr[p];
      total += nfr[p];
    end
    for (int n = 0; n < total; n++) begin
      for (int i = 1; i <= NP; i++) begin
        int q;
        q = (ptr + i) % NP;
        if (rem[q] > 0) begin
          rem[q]--;
          ptr = q;
          if (port_en[q]) exp_order.push_back(q);
          break;
        end
      end
    end
  endtask

  task automatic run_done(string tag);
    int n;
    bit done;
    n = 0;
    done = 0;
    while (!done && n < 3000) begin
      @(negedge clk);
      #2;
      done = !m_tvalid;
      for (int p = 0; p < NP; p++)
        if (src_q[p].size() != 0 ||
            exp_q[p].size() != 0) done = 0;
      n++;
    end
    chk({tag, "_done"}, longint'(done), 1);
    repeat (3) @(posedge clk);
  endtask

  task automatic check_order(string tag);
    chk({tag, "_nframes"}, obs_order.size(),
        exp_order.size());
    for (int i = 0; i < exp_order.size(); i++)
      if (i < obs_order.size())
        chk($sformatf("%s_order%0d", tag, i),
            obs_order[i], exp_order[i]);
  endtask

  task automatic check_model_cnt(string tag);
    #1;
    for (int p = 0; p < NP; p++) begin
      chk($sformatf("%s_fc%0d", tag, p),
          frame_cnt[p], mdl_fc[p]);
      chk($sformatf("%s_dc%0d", tag, p),
          drop_cnt[p], mdl_dc[p]);
    end
  endtask

  vec_t tbl[6];

  initial begin
    rst_n = 1'b0;
    s_tdata = '0;
    s_tkeep = '0;
    s_tvalid = '0;
    s_tlast = '0;
    m_tready = 1'b1;
    port_en = '1;
    cyc = 0;
    clear_obs();
    for (int p = 0; p < NP; p++) src_idx[p] = 0;

    tbl[0] = '{4'b1111, '{3, 0, 3, 0}, '{1, 0, 1, 0},
               '{0, 0, 0, 0}, 6, 0, 4};
    tbl[1] = '{4'b1101, '{0, 3, 0, 0}, '{0, 0, 0, 0},
               '{0, 1, 0, 0}, 0, 0, -1};
    tbl[2] = '{4'b1111, '{0, 6, 0, 0}, '{0, 1, 0, 0},
               '{0, 0, 0, 0}, 4, 1, -1};
    tbl[3] = '{4'b1111, '{0, 0, 4, 0}, '{0, 0, 1, 0},
               '{0, 0, 0, 0}, 4, 0, -1};
    tbl[4] = '{4'b0101, '{1, 2, 5, 3}, '{1, 0, 1, 0},
               '{0, 1, 0, 1}, 5, 1, -1};
    tbl[5] = '{4'b1111, '{1, 1, 1, 1}, '{1, 1, 1, 1},
               '{0, 0, 0, 0}, 4, 0, 2};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_tvalid", m_tvalid, 0);
    chk("rst_tlast", m_tlast, 0);
    chk("rst_terr", m_terr, 0);
    chk("rst_tready", s_tready, 0);
    for (int p = 0; p < NP; p++) begin
      chk("rst_fc", frame_cnt[p], 0);
      chk("rst_dc", drop_cnt[p], 0);
    end

    for (int v = 0; v < 6; v++) begin
      string t;
      t = $sformatf("vec%0d", v);
      do_reset();
      rdy_mode = 0;
      port_en = tbl[v].en;
      for (int p = 0; p < NP; p++) begin
        nfr[p] = (tbl[v].len[p] > 0) ? 1 : 0;
        if (tbl[v].len[p] > 0) load_frame(p, tbl[v].len[p]);
      end
      build_order();
      run_done(t);
      #1;
      for (int p = 0; p < NP; p++) begin
        chk($sformatf("%s_fc%0d", t, p),
            frame_cnt[p], tbl[v].fc[p]);
        chk($sformatf("%s_dc%0d", t, p),
            drop_cnt[p], tbl[v].dc[p]);
        chk($sformatf("%s_rdy%0d", t, p),
            rdy_cyc[p], tbl[v].len[p]);
      end
      chk({t, "_beats"}, n_out, tbl[v].beats);
      chk({t, "_errs"}, n_err, tbl[v].errs);
      check_order(t);
      if (tbl[v].gap >= 0 && obs_cyc.size() >= 2)
        chk({t, "_gap"}, obs_cyc[1] - obs_cyc[0],
            tbl[v].gap);
    end

    // all ports busy: strict rotation of whole frames
    do_reset();
    port_en = '1;
    for (int f = 0; f < 2; f++)
      for (int p = 0; p < NP; p++) load_frame(p, 2);
    for (int p = 0; p < NP; p++) nfr[p] = 2;
    build_order();
    run_done("rr");
    check_order("rr");
    check_model_cnt("rr");

    // downstream stalls 1,0,0,1 on a 4-beat frame
    do_reset();
    rdy_mode = 1;
    port_en = '1;
    nfr[1] = 1;
    load_frame(1, 4);
    build_order();
    run_done("stall");
    check_order("stall");
    check_model_cnt("stall");
    chk("stall_seen", longint'(n_stall > 0), 1);

    // reset mid-frame on port 3
    begin
      int n;
      rdy_mode = 0;
      @(negedge clk);
      #3 load_frame(3, 4);
      n = 0;
      while (src_q[3].size() > 2 && n < 50) begin
        @(negedge clk);
        n++;
      end
      chk("mid_reached", src_q[3].size(), 2);
      #3 rst_n = 1'b0;
      @(posedge clk);
      #1;
      chk("mid_tvalid", m_tvalid, 0);
      chk("mid_tlast", m_tlast, 0);
      chk("mid_tready", s_tready, 0);
      chk("mid_fc1", frame_cnt[1], 0);
      clear_obs();
      src_idx[3] = 0;
      foreach (src_q[3][i]) exp_q[3].push_back(src_q[3][i]);
      mdl_fc[3]++;
      load_frame(0, 1);
      exp_order.push_back(0);
      exp_order.push_back(3);
      @(negedge clk);
      #3 rst_n = 1'b1;
      run_done("mid");
      check_order("mid");
      check_model_cnt("mid");
    end

    // randomized frames, gaps and back-pressure
    for (int r = 0; r < 6; r++) begin
      string t;
      t = $sformatf("rnd%0d", r);
      do_reset();
      port_en = 4'($urandom_range(0, 15));
      rdy_mode = 2;
      gaps = 1;
      for (int p = 0; p < NP; p++) begin
        nfr[p] = $urandom_range(0, 3);
        for (int f = 0; f < nfr[p]; f++)
          load_frame(p, $urandom_range(1, 7));
      end
      build_order();
      run_done(t);
      check_order(t);
      check_model_cnt(t);
      gaps = 0;
    end

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
